param_tile_weight_source: RTL
=============================

PARAM_TILE_WEIGHT_SOURCE -- requirements
Module: param_tile_weight_source

Interface
REQ-001 SHALL have parameter PRECISION, default 16, weight element width in bits.
REQ-002 SHALL have parameter TENSOR_SIZE_DIM_0, default 32, tensor columns.
REQ-003 SHALL have parameter TENSOR_SIZE_DIM_1, default 32, tensor rows.
REQ-004 SHALL have parameters PARALLELISM_DIM_0 and PARALLELISM_DIM_1, default 4 each, tile width and tile height; each divides its tensor size exactly.
REQ-005 SHALL have parameter CONTINUOUS, default 0; 1 = free-running after reset, start ignored.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries, minimum 3.
REQ-007 clk  in  1  clock; all logic on the rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 start  in  1  single-cycle pulse that begins a run; sampled only in IDLE.
REQ-010 repeat_count  in  16  number of full-tensor passes per run, sampled with start; 0 is treated as 1.
REQ-011 busy  out  1  high in every state other than IDLE.
REQ-012 done  out  1  one-cycle pulse when the final beat of a run is accepted.
REQ-013 data_out  out  PRECISION x (P0*P1)  one tile, unpacked array, element j = bits [PRECISION*j +: PRECISION] of the ROM word.
REQ-014 data_out_valid  out  1; data_out_ready  in  1; data_out_last  out  1  marks the final beat of each pass.

Function
REQ-015 BEATS = (T0/P0)*(T1/P1); ROM word width = PRECISION*P0*P1; ROM depth = BEATS; ROM read latency = 2 cycles.
REQ-016 Tile order: DIM_0 tile index fastest, then DIM_1; ROM address = row_tile*(T0/P0) + col_tile.
REQ-017 States: IDLE, ISSUE, DRAIN. IDLE->ISSUE on start; ISSUE->DRAIN after the last address of the last pass is issued; DRAIN->IDLE when that beat is accepted.
REQ-018 A beat transfers only when data_out_valid and data_out_ready are both high.
REQ-019 A ROM read is issued only when (FIFO occupancy + reads in flight) < FIFO_DEPTH; beats are never dropped or duplicated under any ready pattern.
REQ-020 data_out and data_out_last SHALL hold stable while valid is high and ready is low.
REQ-021 Read address wraps from BEATS-1 to 0 and the pass counter increments; data_out_last is set on the beat at address BEATS-1.
REQ-022 With ready held high, the first valid occurs 3 cycles after start is sampled, and throughput is one beat per cycle thereafter.
REQ-023 start while busy SHALL be ignored; done and a new start in the same cycle: the start is ignored.
REQ-024 CONTINUOUS=1: enters ISSUE on the first cycle after reset, loops passes indefinitely, and never asserts done; busy stays high.

Reset
REQ-025 rst SHALL flush the FIFO and in-flight reads, return to IDLE (or ISSUE at address 0 when CONTINUOUS=1), and zero all counters.
REQ-026 rst SHALL drive data_out_valid, data_out_last, done and busy to 0 in the cycle after it is asserted; data_out is don't-care while invalid.
REQ-027 rst asserted mid-run SHALL abandon the run with no done pulse.

Structure
REQ-028 Package param_tile_weight_source_pkg SHALL hold the state enum and a function computing BEATS.
REQ-029 The output buffer SHALL be a sub-module named tile_stream_fifo (synchronous, PRECISION*P0*P1 wide, FIFO_DEPTH entries); the ROM is a second instance with the existing per-parameter ROM interface.

Verification (T0=8, P0=4, T1=4, P1=2, giving BEATS=4)
REQ-030 Start with repeat_count=1 and ready held 1 -> words 0,1,2,3 on 4 consecutive cycles, first valid 3 cycles after start, last on word 3, done in the same cycle as that beat, busy then 0.
REQ-031 repeat_count=3 with ready toggled 1,0 -> 12 beats in address order 0..3 x3, last asserted 3 times, no gaps caused by the source after fill.
REQ-032 ready held 0 for 20 cycles mid-run -> data_out stable, no ROM reads issued beyond FIFO_DEPTH, and the stream resumes with no beat lost.
REQ-033 rst pulsed after beat 2 -> valid 0 the next cycle, no done pulse; a new start replays from address 0.
REQ-034 start pulsed while busy and repeat_count=0 -> the extra start is ignored and repeat_count=0 yields exactly 4 beats.
REQ-035 CONTINUOUS=1 -> after reset, the stream 0,1,2,3,0,1,... runs with start held 0 and done is never asserted.

Source files
------------

// File: rtl/param_tile_weight_source_pkg.sv
// Shared types and sizing helpers for the tiled weight source.
package param_tile_weight_source_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_e;

    localparam int REPEAT_W = 16;

    function automatic int calc_beats(int t0, int p0, int t1, int p1);
        return (t0 / p0) * (t1 / p1);
    endfunction

    function automatic int addr_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/param_tile_weight_rom.sv
// Weight ROM, two-cycle read: registered address, then registered word.
module param_tile_weight_rom #(
    parameter int PRECISION = 16,
    parameter int ELEMS     = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                        clk,
    input  logic [ADDR_W-1:0]           addr,
    output logic [PRECISION*ELEMS-1:0]  data
);

    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [PRECISION*ELEMS-1:0] data_q, data_d;

    // Element j of word a holds a*ELEMS + j.
    always_comb begin
        addr_d = addr;
        data_d = '0;
        for (int j = 0; j < ELEMS; j++) begin
            data_d[PRECISION*j +: PRECISION] =
                PRECISION'(32'(addr_q) * ELEMS + j);
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/tile_stream_fifo.sv
// Synchronous output buffer between the ROM pipeline and the stream port.
module tile_stream_fifo
    import param_tile_weight_source_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = addr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only read behind a nonzero count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/param_tile_weight_source.sv
// Streams tiles of a weight tensor from ROM, DIM_0 tile fastest, repeatable passes.
module param_tile_weight_source
    import param_tile_weight_source_pkg::*;
#(
    parameter int PRECISION         = 16,
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int TENSOR_SIZE_DIM_1 = 32,
    parameter int PARALLELISM_DIM_0 = 4,
    parameter int PARALLELISM_DIM_1 = 4,
    parameter int CONTINUOUS        = 0,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          repeat_count,
    output logic                 busy,
    output logic                 done,
    output logic [PRECISION-1:0] data_out [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 data_out_last
);

    localparam int NE = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
    localparam int W  = PRECISION * NE;
    localparam int NB = calc_beats(TENSOR_SIZE_DIM_0, PARALLELISM_DIM_0,
                                   TENSOR_SIZE_DIM_1, PARALLELISM_DIM_1);
    localparam int AW = addr_width(NB);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam state_e RST_STATE = (CONTINUOUS != 0) ? S_ISSUE : S_IDLE;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] oaddr_q, oaddr_d;
    logic [REPEAT_W-1:0] pass_q, pass_d;
    logic [REPEAT_W-1:0] opass_q, opass_d;
    logic [REPEAT_W-1:0] rep_q, rep_d;
    logic          v1_q, v1_d;
    logic          v2_q, v2_d;

    logic          issue;
    logic          accept;
    logic          olast;
    logic          final_beat;
    logic [CW:0]   credit;
    logic [W-1:0]  rom_data;
    logic [W-1:0]  fifo_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;

    // v1/v2 track reads sitting in the ROM's two pipeline registers.
    assign credit = {1'b0, fifo_count} + {{CW{1'b0}}, v1_q} + {{CW{1'b0}}, v2_q};
    assign issue  = (state_q == S_ISSUE) && (credit < (CW+1)'(FIFO_DEPTH));
    assign accept = !fifo_empty && data_out_ready;
    assign olast  = (oaddr_q == AW'(NB - 1));
    assign final_beat = (CONTINUOUS == 0) && (state_q == S_DRAIN) && accept
                        && olast && (opass_q == rep_q - 16'd1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        oaddr_d = oaddr_q;
        pass_d  = pass_q;
        opass_d = opass_q;
        rep_d   = rep_q;
        v1_d    = issue;
        v2_d    = v1_q;
        if (state_q == S_IDLE && start && CONTINUOUS == 0) begin
            state_d = S_ISSUE;
            rep_d   = (repeat_count == '0) ? 16'd1 : repeat_count;
            addr_d  = '0;
            oaddr_d = '0;
            pass_d  = '0;
            opass_d = '0;
        end
        if (issue) begin
            if (addr_q == AW'(NB - 1)) begin
                addr_d = '0;
                pass_d = pass_q + 16'd1;
                if (CONTINUOUS == 0 && pass_q == rep_q - 16'd1) begin
                    state_d = S_DRAIN;
                end
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
        // Output side keeps its own position so last/done follow accepted beats.
        if (accept) begin
            if (olast) begin
                oaddr_d = '0;
                opass_d = opass_q + 16'd1;
            end else begin
                oaddr_d = oaddr_q + 1'b1;
            end
        end
        if (final_beat) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            addr_q  <= '0;
            oaddr_q <= '0;
            pass_q  <= '0;
            opass_q <= '0;
            rep_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            oaddr_q <= oaddr_d;
            pass_q  <= pass_d;
            opass_q <= opass_d;
            rep_q   <= rep_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
        end
    end

    param_tile_weight_rom #(
        .PRECISION (PRECISION),
        .ELEMS     (NE),
        .ADDR_W    (AW)
    ) u_rom (
        .clk  (clk),
        .addr (addr_q),
        .data (rom_data)
    );

    tile_stream_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (v2_q),
        .push_data (rom_data),
        .pop       (accept),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    for (genvar j = 0; j < NE; j++) begin : g_unpack
        assign data_out[j] = fifo_data[PRECISION*j +: PRECISION];
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = final_beat;
    assign data_out_valid = !fifo_empty;
    assign data_out_last  = !fifo_empty && olast;

endmodule
